// File: rtl/gcl_pkg.sv
// Shared definitions for the LCG test-stream checker and its step function.
package gcl_pkg;
  localparam int unsigned PAYLOAD_W = 32;
  localparam logic [31:0] GCL_A = 32'd69069;
  localparam logic [31:0] GCL_C = 32'd1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } gcl_state_e;
endpackage

// File: rtl/gcl_if.sv
// Stream input and status/counter outputs of the LCG checker.
interface gcl_if #(
  parameter int CNT_W = 32
);
  import gcl_pkg::*;

  logic                 i_Enable;
  logic                 i_Clear;
  logic [63:0]          i_Data;
  logic                 i_Data_valid;
  logic                 o_Locked;
  logic                 o_Error_pulse;
  logic [CNT_W-1:0]     o_Sample_count;
  logic [CNT_W-1:0]     o_Error_count;
  logic [PAYLOAD_W-1:0] o_Expected;
  logic [1:0]           o_State;

  modport master (
    output i_Enable, i_Clear, i_Data, i_Data_valid,
    input  o_Locked, o_Error_pulse, o_Sample_count, o_Error_count, o_Expected, o_State
  );

  modport slave (
    input  i_Enable, i_Clear, i_Data, i_Data_valid,
    output o_Locked, o_Error_pulse, o_Sample_count, o_Error_count, o_Expected, o_State
  );
endinterface

// File: rtl/gcl_next.sv
// One LCG step, f(x) = (A*x + C) mod 2^32, purely combinational.
module gcl_next
  import gcl_pkg::*;
#(
  parameter logic [31:0] A = GCL_A,
  parameter logic [31:0] C = GCL_C
) (
  input  logic [PAYLOAD_W-1:0] x,
  output logic [PAYLOAD_W-1:0] f
);
  // The low half of the 64-bit product depends only on the low operand bits,
  // so a 32-bit multiply gives the truncated result directly.
  assign f = A * x + C;
endmodule

// File: rtl/gcl_checker.sv
// Receive-side checker for the LCG stream: acquires, locks, then counts samples and mismatches.
// Single-cycle accept path, no backpressure; all status visible the cycle after the sample.
module gcl_checker
  import gcl_pkg::*;
#(
  parameter logic [31:0] A          = GCL_A,
  parameter logic [31:0] C          = GCL_C,
  parameter int          LOCK_COUNT = 4,
  parameter int          LOSS_COUNT = 3,
  parameter int          CNT_W      = 32
) (
  input  logic i_Clk,
  input  logic i_Reset,
  gcl_if.slave bus
);
  gcl_state_e           state, state_nxt;
  logic                 seed, seed_nxt;
  logic [3:0]           match_cnt, match_nxt, miss_cnt, miss_nxt;
  logic [PAYLOAD_W-1:0] expected, exp_nxt;
  logic                 pulse, pulse_nxt;
  logic                 samp_inc, err_inc;
  logic [CNT_W-1:0]     sample_cnt, error_cnt;

  logic                 accept, is_match, lose, use_pred;
  logic [3:0]           match_inc, miss_inc;
  logic [PAYLOAD_W-1:0] f_in, f_out;

  assign accept    = bus.i_Enable && bus.i_Data_valid;
  assign is_match  = (bus.i_Data[63:32] == 32'd0) && (bus.i_Data[31:0] == expected);
  assign match_inc = match_cnt + 4'd1;
  assign miss_inc  = miss_cnt + 4'd1;
  assign lose      = (state == LOCKED) && accept && !is_match && (miss_inc == 4'(LOSS_COUNT));
  // Locked prediction free-runs from its own output; everything else reseeds from the data.
  assign use_pred  = (state == LOCKED) && !lose;
  assign f_in      = use_pred ? expected : bus.i_Data[31:0];

  gcl_next #(.A(A), .C(C)) u_next (.x(f_in), .f(f_out));

  always_comb begin
    state_nxt = state;
    seed_nxt  = seed;
    match_nxt = match_cnt;
    miss_nxt  = miss_cnt;
    exp_nxt   = expected;
    pulse_nxt = 1'b0;
    samp_inc  = 1'b0;
    err_inc   = 1'b0;
    if (!bus.i_Enable) begin
      state_nxt = IDLE;
      seed_nxt  = 1'b0;
      match_nxt = 4'd0;
      miss_nxt  = 4'd0;
    end else begin
      case (state)
        IDLE: state_nxt = ACQUIRE;
        ACQUIRE: if (accept) begin
          exp_nxt = f_out;
          if (!seed) begin
            seed_nxt = 1'b1;
          end else if (is_match) begin
            match_nxt = match_inc;
            if (match_inc == 4'(LOCK_COUNT)) begin
              state_nxt = LOCKED;
              miss_nxt  = 4'd0;
            end
          end else begin
            match_nxt = 4'd0;
          end
        end
        LOCKED: if (accept) begin
          samp_inc = 1'b1;
          exp_nxt  = f_out;
          if (is_match) begin
            miss_nxt = 4'd0;
          end else begin
            err_inc   = 1'b1;
            pulse_nxt = 1'b1;
            miss_nxt  = miss_inc;
          end
          if (lose) begin
            state_nxt = ACQUIRE;
            match_nxt = 4'd0;
            miss_nxt  = 4'd0;
            seed_nxt  = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state      <= IDLE;
      seed       <= 1'b0;
      match_cnt  <= 4'd0;
      miss_cnt   <= 4'd0;
      expected   <= '0;
      pulse      <= 1'b0;
      sample_cnt <= '0;
      error_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      seed      <= seed_nxt;
      match_cnt <= match_nxt;
      miss_cnt  <= miss_nxt;
      expected  <= exp_nxt;
      pulse     <= pulse_nxt;
      if (bus.i_Clear)
        sample_cnt <= '0;
      else if (samp_inc && sample_cnt != '1)
        sample_cnt <= sample_cnt + CNT_W'(1);
      if (bus.i_Clear)
        error_cnt <= '0;
      else if (err_inc && error_cnt != '1)
        error_cnt <= error_cnt + CNT_W'(1);
    end
  end

  assign bus.o_Locked       = (state == LOCKED);
  assign bus.o_Error_pulse  = pulse;
  assign bus.o_Sample_count = sample_cnt;
  assign bus.o_Error_count  = error_cnt;
  assign bus.o_Expected     = expected;
  assign bus.o_State        = state;
endmodule

// File: tb/tb_gcl_checker.sv
// Directed bench for gcl_checker: lock, single error, upper bits, loss, reseed, enable, clear, async reset.
module tb_gcl_checker;
  logic i_Clk = 1'b0;
  logic i_Reset;
  int   n_vec = 0;
  int   n_err = 0;
  logic [31:0] cur;
  logic [31:0] wrong;
  logic [31:0] exp_samp, exp_err;

  gcl_if #(.CNT_W(32)) bus ();

  gcl_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3), .CNT_W(32)) dut (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .bus     (bus)
  );

  always #5 i_Clk = ~i_Clk;

  function automatic logic [31:0] lcg(input logic [31:0] x);
    logic [63:0] p;
    p = 64'd69069 * {32'd0, x} + 64'd1;
    return p[31:0];
  endfunction

  task automatic step(input logic [63:0] d, input logic v);
    bus.i_Data       = d;
    bus.i_Data_valid = v;
    @(posedge i_Clk);
    #1;
    bus.i_Data_valid = 1'b0;
    bus.i_Data       = '0;
  endtask

  task automatic test_reset;
    i_Reset = 1'b1;
    bus.i_Enable = 1'b0; bus.i_Clear = 1'b0; bus.i_Data = '0; bus.i_Data_valid = 1'b0;
    #12;
    n_vec++;
    if ({bus.o_Locked, bus.o_Error_pulse, bus.o_State, bus.o_Sample_count, bus.o_Error_count, bus.o_Expected} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got lk=%b ep=%b st=%0d sc=%0d ec=%0d ex=%h, want all 0",
               bus.o_Locked, bus.o_Error_pulse, bus.o_State, bus.o_Sample_count, bus.o_Error_count, bus.o_Expected);
    end
    @(negedge i_Clk); i_Reset = 1'b0;
    step(64'd1, 1'b1);
    n_vec++;
    if (bus.o_State !== 2'd0) begin
      n_err++; $display("FAIL idle_when_disabled: state=%0d want 0", bus.o_State);
    end
  endtask

  task automatic test_lock;
    bus.i_Enable = 1'b1;
    step(64'd0, 1'b0);
    n_vec++;
    if (bus.o_State !== 2'd1) begin
      n_err++; $display("FAIL enter_acquire: state=%0d want 1", bus.o_State);
    end
    step(64'd1, 1'b1);
    n_vec++;
    if (bus.o_Expected !== 32'd69070) begin
      n_err++; $display("FAIL seed_predict: expected=%0d want 69070", bus.o_Expected);
    end
    step(64'd69070, 1'b1);
    step(64'd475628535, 1'b1);
    cur = lcg(32'd475628535);
    n_vec++;
    if (bus.o_Expected !== cur) begin
      n_err++; $display("FAIL acquire_predict: expected=%h want %h", bus.o_Expected, cur);
    end
    step({32'd0, cur}, 1'b1); cur = lcg(cur);
    n_vec++;
    if (bus.o_Locked !== 1'b0) begin
      n_err++; $display("FAIL early_lock: locked=%b want 0 after 4th sample", bus.o_Locked);
    end
    step({32'd0, cur}, 1'b1); cur = lcg(cur);
    n_vec++;
    if ({bus.o_Locked, bus.o_State, bus.o_Sample_count} !== {1'b1, 2'd2, 32'd0}) begin
      n_err++; $display("FAIL lock_5th: lk=%b st=%0d sc=%0d want 1 2 0", bus.o_Locked, bus.o_State, bus.o_Sample_count);
    end
    step({32'd0, cur}, 1'b1); cur = lcg(cur);
    exp_samp = 32'd1; exp_err = 32'd0;
    n_vec++;
    if ({bus.o_Sample_count, bus.o_Error_count, bus.o_Error_pulse, bus.o_Expected} !== {exp_samp, exp_err, 1'b0, cur}) begin
      n_err++; $display("FAIL first_count: sc=%0d ec=%0d ep=%b ex=%h want 1 0 0 %h",
                        bus.o_Sample_count, bus.o_Error_count, bus.o_Error_pulse, bus.o_Expected, cur);
    end
  endtask

  task automatic test_single_error;
    step(64'd0, 1'b1); cur = lcg(cur);
    exp_samp++; exp_err++;
    n_vec++;
    if ({bus.o_Error_pulse, bus.o_Error_count, bus.o_Locked, bus.o_Sample_count} !== {1'b1, exp_err, 1'b1, exp_samp}) begin
      n_err++; $display("FAIL single_error: ep=%b ec=%0d lk=%b sc=%0d want 1 %0d 1 %0d",
                        bus.o_Error_pulse, bus.o_Error_count, bus.o_Locked, bus.o_Sample_count, exp_err, exp_samp);
    end
    for (int i = 0; i < 2; i++) begin
      step({32'd0, cur}, 1'b1); cur = lcg(cur); exp_samp++;
      n_vec++;
      if ({bus.o_Error_pulse, bus.o_Error_count, bus.o_Sample_count, bus.o_Expected} !== {1'b0, exp_err, exp_samp, cur}) begin
        n_err++; $display("FAIL resume_%0d: ep=%b ec=%0d sc=%0d ex=%h want 0 %0d %0d %h",
                          i, bus.o_Error_pulse, bus.o_Error_count, bus.o_Sample_count, bus.o_Expected, exp_err, exp_samp, cur);
      end
    end
  endtask

  task automatic test_upper_bits;
    step({32'h1, cur}, 1'b1); cur = lcg(cur);
    exp_samp++; exp_err++;
    n_vec++;
    if ({bus.o_Error_pulse, bus.o_Error_count, bus.o_Locked} !== {1'b1, exp_err, 1'b1}) begin
      n_err++; $display("FAIL upper_bits: ep=%b ec=%0d lk=%b want 1 %0d 1", bus.o_Error_pulse, bus.o_Error_count, bus.o_Locked, exp_err);
    end
    step({32'd0, cur}, 1'b1); cur = lcg(cur); exp_samp++;
    n_vec++;
    if ({bus.o_Error_pulse, bus.o_Error_count} !== {1'b0, exp_err}) begin
      n_err++; $display("FAIL upper_recover: ep=%b ec=%0d want 0 %0d", bus.o_Error_pulse, bus.o_Error_count, exp_err);
    end
  endtask

  task automatic test_loss;
    for (int i = 0; i < 3; i++) begin
      wrong = cur ^ 32'h8000_0001;
      step({32'd0, wrong}, 1'b1); cur = lcg(cur);
      exp_samp++; exp_err++;
      n_vec++;
      if ({bus.o_Error_pulse, bus.o_Error_count, bus.o_Sample_count, bus.o_State} !==
          {1'b1, exp_err, exp_samp, (i < 2) ? 2'd2 : 2'd1}) begin
        n_err++; $display("FAIL loss_%0d: ep=%b ec=%0d sc=%0d st=%0d want 1 %0d %0d %0d",
                          i, bus.o_Error_pulse, bus.o_Error_count, bus.o_Sample_count, bus.o_State,
                          exp_err, exp_samp, (i < 2) ? 2 : 1);
      end
    end
    cur = lcg(wrong);
    n_vec++;
    if (bus.o_Expected !== cur) begin
      n_err++; $display("FAIL loss_reseed: ex=%h want %h", bus.o_Expected, cur);
    end
    for (int i = 0; i < 4; i++) begin
      step({32'd0, cur}, 1'b1); cur = lcg(cur);
      n_vec++;
      if ({bus.o_Locked, bus.o_Error_count, bus.o_Sample_count} !== {(i == 3), exp_err, exp_samp}) begin
        n_err++; $display("FAIL relock_%0d: lk=%b ec=%0d sc=%0d want %0d %0d %0d",
                          i, bus.o_Locked, bus.o_Error_count, bus.o_Sample_count, (i == 3), exp_err, exp_samp);
      end
    end
  endtask

  task automatic test_enable_low;
    bus.i_Enable = 1'b0;
    step({32'd0, cur ^ 32'h1}, 1'b1);
    n_vec++;
    if ({bus.o_State, bus.o_Locked, bus.o_Error_pulse, bus.o_Error_count, bus.o_Sample_count} !==
        {2'd0, 1'b0, 1'b0, exp_err, exp_samp}) begin
      n_err++; $display("FAIL enable_low: st=%0d lk=%b ep=%b ec=%0d sc=%0d want 0 0 0 %0d %0d",
                        bus.o_State, bus.o_Locked, bus.o_Error_pulse, bus.o_Error_count, bus.o_Sample_count, exp_err, exp_samp);
    end
  endtask

  task automatic test_reseed;
    bus.i_Enable = 1'b1;
    step(64'd0, 1'b0);
    step(64'd5, 1'b1);
    step(64'd7, 1'b1);
    cur = 32'd483484;
    n_vec++;
    if ({bus.o_Expected, bus.o_State, bus.o_Error_count} !== {cur, 2'd1, exp_err}) begin
      n_err++; $display("FAIL reseed_7: ex=%0d st=%0d ec=%0d want 483484 1 %0d", bus.o_Expected, bus.o_State, bus.o_Error_count, exp_err);
    end
    for (int i = 0; i < 4; i++) begin
      step({32'd0, cur}, 1'b1); cur = lcg(cur);
      n_vec++;
      if ({bus.o_Locked, bus.o_Error_count} !== {(i == 3), exp_err}) begin
        n_err++; $display("FAIL reseed_lock_%0d: lk=%b ec=%0d want %0d %0d", i, bus.o_Locked, bus.o_Error_count, (i == 3), exp_err);
      end
    end
  endtask

  task automatic test_clear;
    bus.i_Clear = 1'b1;
    step({32'd0, cur ^ 32'h10}, 1'b1); cur = lcg(cur);
    bus.i_Clear = 1'b0;
    exp_samp = 32'd0; exp_err = 32'd0;
    n_vec++;
    if ({bus.o_Error_pulse, bus.o_Error_count, bus.o_Sample_count, bus.o_Locked} !== {1'b1, exp_err, exp_samp, 1'b1}) begin
      n_err++; $display("FAIL clear_vs_error: ep=%b ec=%0d sc=%0d lk=%b want 1 0 0 1",
                        bus.o_Error_pulse, bus.o_Error_count, bus.o_Sample_count, bus.o_Locked);
    end
    step({32'd0, cur}, 1'b1); cur = lcg(cur); exp_samp++;
    n_vec++;
    if ({bus.o_Error_pulse, bus.o_Error_count, bus.o_Sample_count} !== {1'b0, exp_err, exp_samp}) begin
      n_err++; $display("FAIL after_clear: ep=%b ec=%0d sc=%0d want 0 0 1", bus.o_Error_pulse, bus.o_Error_count, bus.o_Sample_count);
    end
  endtask

  task automatic test_async_reset;
    bus.i_Data = {32'd0, cur}; bus.i_Data_valid = 1'b1;
    @(negedge i_Clk);
    #2 i_Reset = 1'b1;
    #1;
    n_vec++;
    if ({bus.o_Locked, bus.o_Error_pulse, bus.o_State, bus.o_Sample_count, bus.o_Error_count, bus.o_Expected} !== '0) begin
      n_err++; $display("FAIL async_reset: lk=%b ep=%b st=%0d sc=%0d ec=%0d ex=%h want all 0",
                        bus.o_Locked, bus.o_Error_pulse, bus.o_State, bus.o_Sample_count, bus.o_Error_count, bus.o_Expected);
    end
    bus.i_Data_valid = 1'b0;
    @(negedge i_Clk); i_Reset = 1'b0;
    step(64'd0, 1'b0);
    n_vec++;
    if ({bus.o_State, bus.o_Expected} !== {2'd1, 32'd0}) begin
      n_err++; $display("FAIL post_reset_acquire: st=%0d ex=%h want 1 0", bus.o_State, bus.o_Expected);
    end
  endtask

  initial begin
    test_reset;
    test_lock;
    test_single_error;
    test_upper_bits;
    test_loss;
    test_enable_low;
    test_reseed;
    test_clear;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/gcl_checker.md
Name: gcl_checker

Overview:
- Receive-side checker for the pseudo-random test stream produced by the team's linear congruential generator (x_next = (69069*x + 1) mod 2^32, value carried in bits [31:0] of a 64-bit word with a valid strobe).
- Acquires the sequence from the incoming data, locks after a run of correct predictions, then counts checked samples and mismatches.
- Sits at the far end of a data path (FIFO, DMA loopback, filter bypass) to prove lossless, in-order transport.

Parameters:
- A, 69069, LCG multiplier.
- C, 1, LCG increment.
- LOCK_COUNT, 4, consecutive correct predictions needed to enter LOCKED (range 1..15).
- LOSS_COUNT, 3, consecutive mismatches in LOCKED that drop lock (range 1..15).
- CNT_W, 32, width of the sample and error counters.

Ports:
- i_Clk  in  1  clock.
- i_Reset  in  1  asynchronous active-high reset.
- i_Enable  in  1  checker enable; low forces IDLE.
- i_Clear  in  1  synchronous clear of the sample and error counters.
- i_Data  in  64  received word; payload in [31:0], [63:32] must be zero.
- i_Data_valid  in  1  i_Data is valid this cycle.
- o_Locked  out  1  high while the state is LOCKED.
- o_Error_pulse  out  1  one-cycle pulse per mismatch detected in LOCKED.
- o_Sample_count  out  CNT_W  samples checked while LOCKED (saturating).
- o_Error_count  out  CNT_W  mismatches while LOCKED (saturating).
- o_Expected  out  32  value predicted for the next sample.
- o_State  out  2  0=IDLE, 1=ACQUIRE, 2=LOCKED.

Behaviour:
- Reset (async, any time): all outputs and internal registers go to 0; state goes to IDLE; seed flag, match counter and miss counter are cleared.
- Sample acceptance: a sample is accepted only on a cycle where i_Enable=1 and i_Data_valid=1. Back-to-back valids every cycle are supported; the design has no backpressure.
- Next-value function: f(x) = (A*x + C) mod 2^32, using a full 64-bit product truncated to 32 bits, computed in a single cycle.
- Match rule: i_Data[63:32]==0 and i_Data[31:0]==o_Expected. A nonzero upper half is always a mismatch.
- IDLE:
  - Samples are ignored; match and miss counters are zero; seed flag is clear.
  - Counters hold their values.
  - i_Enable=1 moves the state to ACQUIRE on the next edge.
- ACQUIRE:
  - First accepted sample (seed flag clear): set the seed flag; o_Expected <= f(i_Data[31:0]); no comparison.
  - Later samples, match: match_cnt++ and o_Expected <= f(i_Data[31:0]). When match_cnt reaches LOCK_COUNT, go to LOCKED and clear the miss counter.
  - Later samples, mismatch: match_cnt <= 0; the sample becomes the new seed, so o_Expected <= f(i_Data[31:0]).
  - Errors are never counted in ACQUIRE.
- LOCKED:
  - Every accepted sample: o_Sample_count++ and o_Expected <= f(o_Expected). Prediction free-runs, so a single corrupted word costs exactly one error.
  - Match: miss_cnt <= 0.
  - Mismatch: o_Error_count++, o_Error_pulse=1 for one cycle, miss_cnt++.
  - When miss_cnt reaches LOSS_COUNT: go to ACQUIRE, match_cnt <= 0, and the offending sample becomes the new seed (o_Expected <= f(i_Data[31:0]), seed flag set).
- Latency: o_Error_pulse, the counters, o_Locked and o_State all update on the edge that accepts the sample. They are visible the cycle after i_Data_valid.
- i_Enable low in any state: state goes to IDLE on the next edge, o_Locked drops, match and miss counters and the seed flag clear. A sample presented on that cycle is ignored.
- i_Clear: both counters load 0 on the next edge; state is unaffected. If a counting event occurs in the same cycle, the clear wins and the event is not counted, but o_Error_pulse still fires.
- Saturation: both counters hold at 2^CNT_W-1.

Decomposition:
- Package gcl_pkg holds:
  - default A and C;
  - the state encoding constants IDLE/ACQUIRE/LOCKED;
  - the payload width (32).
- One combinational sub-module, gcl_next (input x[31:0], output f(x)), computes the LCG step. It is instantiated once. It is reusable by a future feedback-mode generator, so the transmitter and checker share one definition of the sequence.

Test Plan:
- Lock: reset, enable, feed 1, 69070, 475628535, then 3 more correct successors, one per cycle -> o_Locked rises the cycle after the 5th sample; o_Sample_count=1 after the 6th; o_Error_count=0.
- Single error: when locked, replace one word with 0x0000_0000 then resume the correct sequence -> exactly one o_Error_pulse, o_Error_count=1, o_Locked stays 1, the next correct words match.
- Upper bits: when locked, send the correct payload with [63:32]=0x1 -> counted as a mismatch (o_Error_count +1).
- Loss of lock: when locked, send 3 consecutive wrong words -> 3 error pulses, o_State=1 after the 3rd; a correct sequence seeded from the 3rd wrong word relocks after 4 further matches.
- Acquire reseed: after enable, send 5, 7 (wrong), then f(7), f(f(7)), ... -> no errors counted; lock occurs after 4 matches following seed 7.
- Control: i_Clear coincident with an error -> o_Error_count=0 and pulse seen. i_Enable low mid-stream -> IDLE, counters retained. Async reset asserted mid-clock-cycle -> all outputs 0 immediately.
